// File: rtl/axis_sync_pkt_fifo.sv
// rtl/axis_sync_pkt_fifo.sv - single-clock AXI-Stream FIFO with level, almost-full and output hold
// Optional store-and-forward packet mode: define PACKET_MODE_EN.
module axis_sync_pkt_fifo #(
  parameter int DATA_WIDTH        = 16,
  parameter int ADDR_WIDTH        = 4,
  parameter int ALMOST_FULL_LEVEL = 12
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [DATA_WIDTH-1:0]   s_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_tkeep,
  input  logic                    s_tlast,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  output logic [DATA_WIDTH-1:0]   m_tdata,
  output logic [DATA_WIDTH/8-1:0] m_tkeep,
  output logic                    m_tlast,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  input  logic                    m_hold,
  output logic [ADDR_WIDTH:0]     level,
  output logic                    almost_full
);

  localparam int KEEP_WIDTH  = DATA_WIDTH / 8;
  localparam int ENTRY_WIDTH = DATA_WIDTH + KEEP_WIDTH + 1;
  localparam int DEPTH       = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_CNT = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AF_CNT   = ALMOST_FULL_LEVEL[ADDR_WIDTH:0];

  logic [ENTRY_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  wr_en, rd_en, drain_ok;

`ifdef PACKET_MODE_EN
  logic [ADDR_WIDTH:0]   pkt_cnt_q, pkt_cnt_d;

  // A full FIFO holding no complete packet must still drain, or it deadlocks.
  assign drain_ok = (pkt_cnt_q != '0) || (count_q == FULL_CNT);
`else
  assign drain_ok = 1'b1;
`endif

  assign s_tready    = (count_q != FULL_CNT);
  assign m_tvalid    = (count_q != '0) && !m_hold && drain_ok;
  assign level       = count_q;
  assign almost_full = (count_q >= AF_CNT);

  assign wr_en = s_tvalid && s_tready;
  assign rd_en = m_tvalid && m_tready;

  assign {m_tlast, m_tkeep, m_tdata} = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

`ifdef PACKET_MODE_EN
  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    case ({wr_en && s_tlast, rd_en && m_tlast})
      2'b10:   pkt_cnt_d = pkt_cnt_q + 1'b1;
      2'b01:   pkt_cnt_d = pkt_cnt_q - 1'b1;
      default: pkt_cnt_d = pkt_cnt_q;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) pkt_cnt_q <= '0;
    else        pkt_cnt_q <= pkt_cnt_d;
  end
`endif

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; a beat offered during reset is dropped.
  always_ff @(posedge aclk) begin
    if (wr_en && !areset) mem_q[wr_ptr_q] <= {s_tlast, s_tkeep, s_tdata};
  end

endmodule
